// File: rtl/p2s_scheduler.sv
// Round-robin arbiter that shares one parallel-to-serial shifter among N_REQ requesters.
// It drives the shifter's start level, tracks its sen strobe, and reports done or timeout per transaction.
`timescale 1ns/1ps

module p2s_scheduler #(
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned START_HOLD = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic                       busy,
    output logic                       p2s_start,
    output logic [DATA_BITS-1:0]       p2s_data,
    input  logic                       p2s_sen
);

    localparam int unsigned    IDXW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned    HOLDW     = $clog2(START_HOLD);
    localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(START_HOLD - 1);
    localparam logic [7:0]     TMO       = 8'(TIMEOUT);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_FINISH
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [IDXW-1:0]        r_last, w_last_nxt;
    logic [IDXW-1:0]        r_win, w_win_nxt;
    logic [7:0]             r_tcnt, w_tcnt_nxt;
    logic [HOLDW-1:0]       r_hold, w_hold_nxt;
    logic                   r_seen, w_seen_nxt;
    logic [N_REQ-1:0]       r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]       r_done, w_done_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_start, w_start_nxt;
    logic [DATA_BITS-1:0]   r_data, w_data_nxt;

    logic                   w_found;
    logic [IDXW-1:0]        w_cand;
    logic [IDXW-1:0]        w_pick;
    logic [N_REQ-1:0]       w_pick_oh;
    logic [DATA_BITS-1:0]   w_word;
    logic                   w_seen_now;
    logic                   w_tmo;

    // Search starts just after the previous winner, so that requester ranks lowest next time.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_pick  = r_last;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_cand = IDXW'((32'(r_last) + k) % N_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        w_word    = '0;
        w_pick_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (32'(w_pick) == i) begin
                w_word       = req_data[i*DATA_BITS +: DATA_BITS];
                w_pick_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_win_nxt   = r_win;
        w_tcnt_nxt  = r_tcnt;
        w_hold_nxt  = r_hold;
        w_seen_nxt  = r_seen;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_start_nxt = r_start;
        w_data_nxt  = r_data;
        w_seen_now  = r_seen | ~p2s_sen;
        w_tmo       = (r_tcnt == TMO);

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_START;
                    w_win_nxt   = w_pick;
                    w_gnt_nxt   = w_pick_oh;
                    w_data_nxt  = w_word;
                    w_start_nxt = 1'b1;
                    w_tcnt_nxt  = '0;
                    w_hold_nxt  = '0;
                    w_seen_nxt  = 1'b0;
                end
            end
            S_START: begin
                w_tcnt_nxt = r_tcnt + 8'd1;
                w_hold_nxt = r_hold + 1'b1;
                w_seen_nxt = w_seen_now;
                if (!w_seen_now && w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_gnt_nxt   = '0;
                    w_start_nxt = 1'b0;
                    w_state_nxt = S_FINISH;
                end else if (r_hold == HOLD_LAST) begin
                    // A sen drop already seen while start was held means shifting is under way.
                    w_start_nxt = 1'b0;
                    w_state_nxt = w_seen_now ? S_WAIT_DONE : S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                w_tcnt_nxt = r_tcnt + 8'd1;
                if (!p2s_sen) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_tmo) begin
                    w_err_nxt   = 1'b1;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_FINISH;
                end
            end
            S_WAIT_DONE: begin
                if (p2s_sen) begin
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_last_nxt  = r_win;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_last  <= LAST_RST;
            r_win   <= '0;
            r_tcnt  <= '0;
            r_hold  <= '0;
            r_seen  <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_start <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_win   <= w_win_nxt;
            r_tcnt  <= w_tcnt_nxt;
            r_hold  <= w_hold_nxt;
            r_seen  <= w_seen_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_start <= w_start_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign p2s_start = r_start;
    assign p2s_data  = r_data;

endmodule

// File: doc/p2s_scheduler.md
# p2s_scheduler

Round-robin scheduler that shares one parallel-to-serial shifter (the seg7/LED serial driver) among `N_REQ` requesters. It sits between the display and status sources and the shifter. Each cycle it arbitrates pending requests, latches the winner's word onto the shifter data bus, and generates the `start` level for the shifter. It then tracks the shifter's `sen` strobe and returns a per-requester completion pulse, or an error pulse if the shifter never starts.

## Interface
Parameters:
- `DATA_BITS`, 16: width of one serial word; must match the shifter.
- `N_REQ`, 2: number of requesters (2..8).
- `START_HOLD`, 4: cycles `p2s_start` stays high per transaction (≥3).
- `TIMEOUT`, 255: max cycles from start assertion to `sen` falling (1..255).

Ports:
- `clk`, in, 1: single clock; every register uses its rising edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `req`, in, N_REQ: level request per requester; held until its `done` pulse.
- `req_data`, in, N_REQ*DATA_BITS: word for requester i in bits [i*DATA_BITS +: DATA_BITS].
- `gnt`, out, N_REQ: one-hot grant, high for the whole transaction.
- `done`, out, N_REQ: one-cycle pulse to the granted requester on successful completion.
- `err`, out, 1: one-cycle pulse on timeout; `done` is not pulsed for that transaction.
- `busy`, out, 1: high in every state except IDLE.
- `p2s_start`, out, 1: start level to the shifter.
- `p2s_data`, out, DATA_BITS: latched word to the shifter.
- `p2s_sen`, in, 1: shifter enable strobe; low while shifting, high when idle or finished.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE: if any `req` bit is set, pick the winner round-robin, starting at index `last+1` mod N_REQ.
  - On reset `last` = N_REQ-1, so `req[0]` has highest priority first.
  - Winner's `gnt` is registered and its word is latched into `p2s_data`.
  - `p2s_start` goes to 1; the timeout counter and hold counter clear. Next state is START.
- START: `p2s_start` = 1 for `START_HOLD` cycles total, then 0. Next state is WAIT_BUSY.
  - `p2s_sen` falling during START is recorded, and WAIT_BUSY is then skipped.
- WAIT_BUSY: wait for `p2s_sen` = 0, then go to WAIT_DONE.
- WAIT_DONE: wait for `p2s_sen` = 1, then go to FINISH. No timeout in this state.
- FINISH: pulse `done[winner]`, clear `gnt`, set `last` = winner, return to IDLE.
- Timeout: the 8-bit counter starts at start assertion and runs through START and WAIT_BUSY.
  - When it reaches `TIMEOUT` with `sen` never seen low, pulse `err`, clear `gnt`, and go to FINISH without pulsing `done`.
  - `last` still advances after a timeout.
- Deasserting `req` mid-transaction has no effect: the transaction runs to completion and `done` still pulses.
- `req_data` is sampled only in the IDLE grant cycle. Later changes are ignored.
- `p2s_data` holds its last word after the transaction; it is not cleared.

## Timing
- Reset values: `gnt` = 0, `done` = 0, `err` = 0, `busy` = 0, `p2s_start` = 0, `p2s_data` = 0, state IDLE, `last` = N_REQ-1, counters 0.
- `rstn` low mid-transaction forces reset values immediately, even though the shifter may still be shifting.
- All outputs are registered; there is no combinational path from input to output.
- Grant latency: `req` sampled high at edge k gives `gnt`, `p2s_start` and `p2s_data` valid after edge k.
- `p2s_start` is high for exactly `START_HOLD` cycles.
- At least one IDLE cycle with `p2s_start` = 0 separates transactions, so the shifter always sees a rising edge.
- Re-arbitration: the earliest next grant is 2 cycles after `done` (FINISH → IDLE → grant).
  - A requester that keeps `req` high after `done` has lowest priority at that arbitration.
- `done`/`err` rises one cycle after the `sen` rise (or the timeout) is sampled.

## Test plan
- **Single request:** N_REQ=2, `req` = 01, data0 = 16'hA5C3.
  - `gnt` = 01 and `p2s_data` = A5C3 one cycle later; `p2s_start` high for 4 cycles.
  - Shifter model drops `sen` for 17 cycles; `done[0]` pulses one cycle after `sen` rises.
- **Contention round-robin:** `req` = 11 held continuously.
  - Grants go 0, 1, 0, 1; each `done` matches its `gnt`; `p2s_start` is low for ≥1 cycle between transactions.
- **Timeout:** TIMEOUT=20, `sen` stuck high.
  - `err` pulses 21 cycles after the grant cycle; `done` = 0; `gnt` clears.
  - A following request is granted to the other requester.
- **Request withdrawn:** `req[1]` drops during WAIT_DONE.
  - Transaction completes, `done[1]` pulses, no new grant.
- **Data stability:** `req_data` changes during START.
  - `p2s_data` keeps the word latched at grant.
- **Async reset mid-WAIT_DONE:** pull `rstn` low between edges.
  - All outputs 0 immediately; after release, `req` = 11 is granted to index 0 first.
